// File: rtl/turn_input_conditioner.sv
// turn_input_conditioner
//   Conditions the three raw tail-light switches (hazard, left, right) and
//   produces the step enable for the tail-light sequencer.
//   Each switch is synchronized with two flops and debounced by its own counter.
//   A free-running divider pulses step_tick once every TICK_DIV cycles. Any
//   change on a conditioned output restarts the divider and pulses step_tick
//   on the next cycle, so the sequencer reacts at once.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles before an output follows (1..255)
//   TICK_DIV         step_tick period in clk cycles (2..65535)
//
// Configuration macro
//   TURN_HAZARD_LATCH_EN  when defined, each debounced press of the hazard
//                         switch toggles hazard. When undefined, hazard
//                         follows the debounced switch level.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   hazard_in  in   raw hazard switch (asynchronous)
//   left_in    in   raw left-turn switch (asynchronous)
//   right_in   in   raw right-turn switch (asynchronous)
//   hazard     out  registered hazard request
//   left       out  registered debounced left request
//   right      out  registered debounced right request
//   step_tick  out  registered one-cycle sequencer step enable

module turn_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TICK_DIV        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic hazard_in,
  input  logic left_in,
  input  logic right_in,
  output logic hazard,
  output logic left,
  output logic right,
  output logic step_tick
);

  localparam int unsigned NCH  = 3;
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TK_W = $clog2(TICK_DIV);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);

  // Channel index: 0 = hazard, 1 = left, 2 = right
  logic [NCH-1:0]  raw;
  logic [NCH-1:0]  s1_q, s2_q;
  logic [NCH-1:0]  db_q, db_d;
  logic [DB_W-1:0] cnt_q [NCH];
  logic [DB_W-1:0] cnt_d [NCH];

  logic            hazard_q, hazard_d;
  logic [TK_W-1:0] tick_q, tick_d;
  logic            step_q, step_d;
  logic            restart;

  assign raw = {right_in, left_in, hazard_in};

  // Per-channel debounce: follow s2 only after it has differed for DEBOUNCE_CYCLES edges
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        db_d[i]  = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DB_W'(1);
      end
    end
  end

  // Hazard request: level follower or press-toggle latch
  always_comb begin
`ifdef TURN_HAZARD_LATCH_EN
    hazard_d = hazard_q ^ (db_d[0] & ~db_q[0]);
`else
    hazard_d = db_d[0];
`endif
  end

  // Divider with restart. A restart right after a pulse reuses that pulse,
  // so step_tick is never high on two consecutive cycles.
  always_comb begin
    restart = (hazard_d != hazard_q) || (db_d[2:1] != db_q[2:1]);
    tick_d  = tick_q + TK_W'(1);
    if (restart || (tick_q == TK_LAST)) begin
      tick_d = '0;
    end
    step_d = (restart || (tick_q == TK_LAST)) && !step_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      db_q     <= '0;
      hazard_q <= 1'b0;
      tick_q   <= '0;
      step_q   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      db_q     <= db_d;
      hazard_q <= hazard_d;
      tick_q   <= tick_d;
      step_q   <= step_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign hazard    = hazard_q;
  assign left      = db_q[1];
  assign right     = db_q[2];
  assign step_tick = step_q;

endmodule

// File: tb/tb_turn_input_conditioner.sv
// Directed bench for turn_input_conditioner (DEBOUNCE_CYCLES=4, TICK_DIV=8).
// Outputs are sampled 1 time unit after each rising edge. step_tick expectations
// come from a reference divider that is restarted at hand-marked edges.

module tb_turn_input_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic hazard_in, left_in, right_in;
  logic hazard, left, right, step_tick;

  int vectors     = 0;
  int miscompares = 0;
  int ref_cnt     = 0;
  bit prev_step   = 1'b0;

  turn_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV       (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .hazard_in(hazard_in),
    .left_in  (left_in),
    .right_in (right_in),
    .hazard   (hazard),
    .left     (left),
    .right    (right),
    .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  // One clock while in reset: everything must read 0
  task automatic cyc_rst();
    @(posedge clk);
    #1;
    ref_cnt   = 0;
    prev_step = 1'b0;
    chk("rst_hazard", hazard, 1'b0);
    chk("rst_left", left, 1'b0);
    chk("rst_right", right, 1'b0);
    chk("rst_step", step_tick, 1'b0);
  endtask

  // One clock of normal operation; restart marks an edge where an output changes
  task automatic cyc(input bit restart, input logic eh, input logic el, input logic er);
    bit es;
    @(posedge clk);
    #1;
    es        = (restart || ref_cnt == 7) && !prev_step;
    ref_cnt   = (restart || ref_cnt == 7) ? 0 : ref_cnt + 1;
    prev_step = es;
    chk("hazard", hazard, eh);
    chk("left", left, el);
    chk("right", right, er);
    chk("step_tick", step_tick, es);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit hraw, hexp, hrs;

    // Reset with all switches on
    reset = 1'b1; hazard_in = 1'b1; left_in = 1'b1; right_in = 1'b1;
    repeat (3) cyc_rst();

    // Release: no restart, first step_tick on the 8th edge, then every 8
    reset = 1'b0; hazard_in = 1'b0; left_in = 1'b0; right_in = 1'b0;
    for (int e = 1; e <= 7; e++) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("first_tick_edge8", step_tick, 1'b1);
    for (int e = 9; e <= 17; e++) cyc(0, 0, 0, 0);

    // Left press: output at edge k+5 with a restart pulse
    left_in = 1'b1;
    for (int e = 0; e <= 4; e++) cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 0);
    chk("left_restart_pulse", step_tick, 1'b1);
    for (int e = 0; e < 7; e++) cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("tick_8_after_restart", step_tick, 1'b1);
    cyc(0, 0, 1, 0);

    // Right glitch of 3 cycles: filtered, no restart
    right_in = 1'b1;
    repeat (3) cyc(0, 0, 1, 0);
    right_in = 1'b0;
    repeat (10) cyc(0, 0, 1, 0);

    // Left release, then left and right together
    left_in = 1'b0;
    repeat (5) cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    left_in = 1'b1; right_in = 1'b1;
    repeat (5) cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 1);
    repeat (3) cyc(0, 0, 1, 1);

    // Reset with divider at 5 and left/right held high
    for (int i = 0; i < 8 && ref_cnt != 5; i++) cyc(0, 0, 1, 1);
    chk("divider_at_5", 1'(ref_cnt == 5), 1'b1);
    reset = 1'b1;
    cyc_rst();
    reset = 1'b0;
    repeat (5) cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 1);
    chk("left_reasserted", left, 1'b1);
    repeat (2) cyc(0, 0, 1, 1);

    // Two 10-cycle hazard presses
    for (int t = 0; t < 50; t++) begin
      hraw = (t < 10) || (t >= 20 && t < 30);
`ifdef TURN_HAZARD_LATCH_EN
      hexp = (t >= 5 && t < 25);
      hrs  = (t == 5) || (t == 25);
`else
      hexp = (t >= 5 && t < 15) || (t >= 25 && t < 35);
      hrs  = (t == 5) || (t == 15) || (t == 25) || (t == 35);
`endif
      hazard_in = hraw;
      cyc(hrs, hexp, 1, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/turn_input_conditioner.md
TURN_INPUT_CONDITIONER -- requirements
Module: turn_input_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4; consecutive stable cycles required before a debounced output changes; legal range 1..255.
REQ-002 Parameter: TICK_DIV, default 8; step_tick period in clk cycles; legal range 2..65535.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 hazard_in  input  1  raw asynchronous hazard switch.
REQ-006 left_in  input  1  raw asynchronous left-turn switch.
REQ-007 right_in  input  1  raw asynchronous right-turn switch.
REQ-008 hazard  output  1  registered debounced (or latched) hazard request, consumed by the tail-light sequencer.
REQ-009 left  output  1  registered debounced left request.
REQ-010 right  output  1  registered debounced right request.
REQ-011 step_tick  output  1  registered one-cycle clock enable that advances the tail-light sequencer.

Function
REQ-012 Each raw input SHALL pass through a private 2-flop synchronizer (s1, s2) before any other logic.
REQ-013 Each channel SHALL have an independent debounce counter sized ceil(log2(DEBOUNCE_CYCLES+1)) bits.
REQ-014 Debounce per edge: if s2 equals the output, the counter SHALL be cleared; else if the counter equals DEBOUNCE_CYCLES-1, the output SHALL load s2 and the counter SHALL clear; else the counter SHALL increment.
REQ-015 A raw change held stable SHALL appear on the output at the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new raw value as edge 1.
REQ-016 A raw change shorter than DEBOUNCE_CYCLES cycles at s2 SHALL leave the output unchanged and clear the counter.
REQ-017 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each follow REQ-014 without interaction.
REQ-018 The tick counter SHALL be sized ceil(log2(TICK_DIV)) bits and count 0..TICK_DIV-1, wrapping to 0.
REQ-019 step_tick SHALL be registered as (tick counter == TICK_DIV-1), giving one-cycle pulses every TICK_DIV cycles.
REQ-020 On any edge where hazard, left, or right changes value, the tick counter SHALL load 0 and step_tick SHALL be 1 in the following cycle (restart).
REQ-021 When a restart coincides with a natural wrap, exactly one step_tick pulse SHALL be produced.
REQ-022 step_tick SHALL never be high for two consecutive cycles when TICK_DIV >= 2.

Reset
REQ-023 While reset is high at a rising edge, all synchronizer flops, debounce counters, the tick counter, hazard, left, right, and step_tick SHALL be 0 after that edge.
REQ-024 Reset SHALL take priority over every other update, including in-progress debounce counts and restarts.
REQ-025 Reset asserted mid-operation SHALL discard all partial counts; after release, the first step_tick SHALL occur at the TICK_DIV-th edge.
REQ-026 Release of reset SHALL NOT by itself cause a restart pulse.

Configuration
REQ-027 Macro TURN_HAZARD_LATCH_EN: when defined, hazard SHALL toggle on each 0->1 transition of the debounced hazard_in and hold otherwise, cleared only by reset; a toggle counts as a change for REQ-020.
REQ-028 When TURN_HAZARD_LATCH_EN is undefined, hazard SHALL equal the debounced level of hazard_in, exactly like left and right.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=8)
REQ-029 Reset held 3 cycles with all inputs 1 -> hazard=left=right=step_tick=0 throughout; first step_tick at the 8th edge after release, then every 8 cycles, 1 cycle wide.
REQ-030 left_in 0->1 sampled at edge k, held -> left=1 after edge k+5; step_tick=1 in the cycle after edge k+5; next pulse 8 cycles later.
REQ-031 right_in high for 3 cycles then low -> right stays 0, no restart, step_tick cadence unchanged.
REQ-032 left_in and right_in rise together -> both outputs rise at the same edge; exactly one restart pulse.
REQ-033 left=1 with tick counter at 5, reset pulsed 1 cycle -> next cycle all outputs 0, counter 0; left re-asserts 6 edges after release.
REQ-034 Two 10-cycle hazard_in pulses: with TURN_HAZARD_LATCH_EN, hazard goes 1 after the first and 0 after the second; without it, hazard tracks each pulse, delayed by 6 edges.
